// File: rtl/uart_pkg.sv
// Shared UART types and helpers, common to uart_tx and uart_rx.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    // Bit period in system clocks, rounded to nearest.
    function automatic int clks_per_baud(input int clk_rate, input int baud_rate);
        return (clk_rate + baud_rate / 2) / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: tick pulses on the last clock of each bit period.
// Latency: counter sits at 0 while restart is high; first tick CLKS_PER_BAUD-1 cycles after release.
// Backpressure: none; free-running whenever restart is low.
module uart_baud_gen #(
    parameter int CLKS_PER_BAUD = 7
) (
    input  logic clk,
    input  logic areset,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BAUD > 1) ? $clog2(CLKS_PER_BAUD) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_W'(CLKS_PER_BAUD - 1));

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            cnt <= '0;
        end else if (restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1/8N2 UART transmitter with a one-entry holding register; even parity with UART_TX_PARITY_EN.
// Latency: byte accepted at edge E0 drives the start bit from edge E1; frames run back-to-back.
// Backpressure: ready is low while the holding register is full.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_RATE  = 50000000,
    parameter int BAUD_RATE = 115200,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       areset,
    input  logic [7:0] data,
    input  logic       data_val,
    output logic       ready,
    output logic       tx,
    output logic       busy
);

    localparam int CLKS_PER_BAUD = clks_per_baud(CLK_RATE, BAUD_RATE);
    localparam int BIT_W         = $clog2(UART_DATA_BITS);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(UART_DATA_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

    generate
        if (CLKS_PER_BAUD < 2 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_cfg
            $error("uart_tx: CLKS_PER_BAUD must be >= 2 and STOP_BITS must be 1 or 2");
        end
    endgenerate

    uart_tx_state_t             state, state_nxt;
    logic                       tx_r, tx_nxt;
    logic [UART_DATA_BITS-1:0]  shift, shift_nxt;
    logic [UART_DATA_BITS-1:0]  hold;
    logic                       hold_full;
    logic [BIT_W-1:0]           bit_cnt, bit_cnt_nxt;
    logic                       load;
    logic                       tick;
    logic                       accept;
`ifdef UART_TX_PARITY_EN
    logic                       par;
`endif

    assign ready  = ~hold_full;
    assign busy   = (state != IDLE) | hold_full;
    assign tx     = tx_r;
    assign accept = data_val & ready;

    // The counter is held at zero in IDLE so the start bit gets a full period.
    uart_baud_gen #(
        .CLKS_PER_BAUD(CLKS_PER_BAUD)
    ) u_baud_gen (
        .clk    (clk),
        .areset (areset),
        .restart(state == IDLE),
        .tick   (tick)
    );

    always_comb begin
        state_nxt   = state;
        tx_nxt      = tx_r;
        shift_nxt   = shift;
        bit_cnt_nxt = bit_cnt;
        load        = 1'b0;
        case (state)
            IDLE: begin
                tx_nxt = 1'b1;
                if (hold_full) begin
                    load      = 1'b1;
                    state_nxt = START;
                    tx_nxt    = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    state_nxt   = DATA;
                    bit_cnt_nxt = '0;
                    tx_nxt      = shift[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt == LAST_DATA) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt = PARITY;
                        tx_nxt    = par;
`else
                        state_nxt   = STOP;
                        tx_nxt      = 1'b1;
                        bit_cnt_nxt = '0;
`endif
                    end else begin
                        shift_nxt   = shift >> 1;
                        tx_nxt      = shift[1];
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_nxt   = STOP;
                    tx_nxt      = 1'b1;
                    bit_cnt_nxt = '0;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (bit_cnt == LAST_STOP) begin
                        if (hold_full) begin
                            load      = 1'b1;
                            state_nxt = START;
                            tx_nxt    = 1'b0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
        if (load) begin
            shift_nxt = hold;
        end
    end

    // accept and load are mutually exclusive: load needs hold_full, accept needs ~hold_full.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state     <= IDLE;
            tx_r      <= 1'b1;
            shift     <= '0;
            bit_cnt   <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
        end else begin
            state   <= state_nxt;
            tx_r    <= tx_nxt;
            shift   <= shift_nxt;
            bit_cnt <= bit_cnt_nxt;
            if (accept) begin
                hold      <= data;
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            par <= 1'b0;
        end else if (load) begin
            par <= ^hold;
        end
    end
`endif

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8-bit asynchronous serial transmitter, the line-side peer of uart_rx.
- Accepts bytes over a valid/ready handshake into a one-entry holding register and serialises them as 8N1 frames, LSB first, on tx.
- Sits between the on-chip byte producer and the pad; its tx output drives the far end's uart_rx rx input.
- One holding register plus one shift register allows gap-free back-to-back frames.

Parameters:
- CLK_RATE, 50000000, system clock frequency in Hz.
- BAUD_RATE, 115200, line rate in bits per second.
- STOP_BITS, 1, number of stop bits; legal values are 1 or 2.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- areset  input  1  asynchronous, active-high reset.
- data  input  8  byte to transmit.
- data_val  input  1  data is valid this cycle.
- ready  output  1  holding register empty; a transfer occurs on a rising edge where data_val && ready.
- tx  output  1  serial line, registered, idles high.
- busy  output  1  high while a frame is in flight or the holding register is full.

Behaviour:
- Bit period: CLKS_PER_BAUD = (CLK_RATE + BAUD_RATE/2) / BAUD_RATE, rounded to nearest; this is a localparam.
- Elaborate-time error if CLKS_PER_BAUD < 2 or STOP_BITS is not 1 or 2.
- Reset values (asynchronous, held while areset is high): tx=1, state=IDLE, hold_full=0, baud counter=0, bit_cnt=0, ready=1, busy=0. No transfer is accepted while areset is high.
- ready = ~hold_full (combinational from the flop). busy = (state != IDLE) | hold_full.
- Accept: on an edge where data_val && ready, hold <= data and hold_full <= 1. data is ignored when not accepted.
- State machine is IDLE -> START -> DATA -> STOP.
  - IDLE: tx=1. If hold_full is set at an edge, load the shifter from hold, clear hold_full, go to START, and drive tx=0 from that edge.
  - Latency: byte accepted at edge E0 gives tx low from edge E1.
  - START: tx=0 for CLKS_PER_BAUD cycles, then go to DATA with bit_cnt=0.
  - DATA: tx = shift[0] for CLKS_PER_BAUD cycles per bit; shift right after each bit. After bit_cnt reaches 7, go to STOP.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BAUD cycles.
  - At the final STOP cycle, if hold_full is set, load the shifter and go straight to START with no idle cycle between frames; otherwise go to IDLE.
- Holding register during a frame: ready goes high the cycle after the shifter loads, so byte N+1 may be accepted at any point during frame N.
- Accept and load on the same edge cannot occur: loading requires hold_full=1, which forces ready=0.
- Frame length: (10 + STOP_BITS - 1) * CLKS_PER_BAUD cycles with parity disabled.
- Reset mid-frame: tx returns high immediately and asynchronously; a partial frame is abandoned and the held byte is discarded.
- data_val held high continuously: one byte is transferred per holding-register vacancy, and none is dropped or duplicated.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx carries even parity (XOR of the 8 data bits) for one bit period.
  - Frame length is one bit period longer.
- When undefined: the PARITY state and the parity logic are absent, and the frame is 8N1/8N2.
- The uart_rx build must use the same macro setting.

Decomposition:
- Package uart_pkg holds:
  - the typedef uart_tx_state_t enum {IDLE, START, DATA, PARITY, STOP};
  - the function clks_per_baud(clk_rate, baud_rate) implementing the rounding rule above, shared with uart_rx;
  - the constant UART_DATA_BITS = 8.
- Sub-module uart_baud_gen:
  - counter that restarts to 0 on a "restart" input and pulses "tick" on the last cycle of each bit period;
  - parameterised by CLKS_PER_BAUD.
  - uart_tx instantiates it once.

Test Plan (CLK_RATE=8125, BAUD_RATE=1200, so CLKS_PER_BAUD=7, STOP_BITS=1):
- Reset: pulse areset mid-frame -> tx=1, ready=1, busy=0 in the same cycle; next frame starts cleanly.
- Single byte 0x68 -> tx low one cycle after accept. The bit sequence 0 | 0,0,0,1,0,1,1,0 | 1 is held 7 clocks per bit (70 clocks total). busy falls after the stop bit.
- Back-to-back: drive 0x68, 0x65, 0x6C, 0x6C, 0x6F, 0x0A with data_val held high -> ready is low exactly while hold_full is set, there are zero idle cycles between stop and start bits, and exactly 6 frames are sent.
- Loopback: tx wired to uart_rx (ready=1), sending "hello\n" -> uart_rx emits 0x68, 0x65, 0x6C, 0x6C, 0x6F, 0x0A with data_val one cycle each and baud_rate_error never asserted.
- Handshake stall: data_val pulsed while ready=0 -> byte not accepted, no frame generated, held byte unchanged.
- UART_TX_PARITY_EN defined: 0x68 -> parity bit 1 after data bit 7, 77-clock frame. 0x55 -> parity bit 0.
